// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // Integer number of system clocks in one bit period.
   function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART receiver.
// Counts from zero after restart and pulses tick when it reaches either the
// half-bit or the full-bit target, then starts the next period from zero.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic half,
   output logic tick
);
   import uart_pkg::*;

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] target;

   assign target = half ? CNT_W'(HALF_BIT - 1) : CNT_W'(CLKS_PER_BIT - 1);
   assign tick   = !restart && (count == target);

   // Free-running period counter, held at zero while restart is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (restart || tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Start bit is confirmed at its centre; every later bit is sampled one bit
// period after the previous sample. Only good frames update data_out.
module uart_rx #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_error
);
   import uart_pkg::*;

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
   localparam int BIT_CNT_W    = $clog2(DATA_BITS);

   rx_state_t state;
   rx_state_t state_next;

   logic                 rx_meta;
   logic                 rx_sync;
   logic                 rx_prev;
   logic                 tick;
   logic                 restart;
   logic                 half;
   logic                 shift_en;
   logic                 clr_bits;
   logic                 stop_eval;
   logic                 frame_ok;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
   logic                 parity_en;
   logic                 parity_bit;
`endif

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .restart(restart),
      .half   (half),
      .tick   (tick)
   );

   // Two-flop synchronizer plus a delayed copy for falling-edge detection;
   // all flops reset to the idle-high line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control decode; nothing happens between bit-period ticks.
   always_comb begin
      state_next = state;
      restart    = 1'b0;
      half       = 1'b0;
      shift_en   = 1'b0;
      clr_bits   = 1'b0;
      stop_eval  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_en  = 1'b0;
`endif
      case (state)
         IDLE: begin
            restart = 1'b1;
            if (rx_prev && !rx_sync) begin
               state_next = START;
               clr_bits   = 1'b1;
            end
         end
         START: begin
            half = 1'b1;
            if (tick) begin
               if (!rx_sync) begin
                  state_next = DATA;
                  clr_bits   = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shift_en = 1'b1;
               if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               parity_en  = 1'b1;
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               stop_eval  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Bit counter and LSB-first shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         if (clr_bits) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
         end
         if (shift_en) begin
            shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Captured parity bit; even parity means data plus parity has an even number of ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_bit <= 1'b0;
      end else if (parity_en) begin
         parity_bit <= rx_sync;
      end
   end

   assign frame_ok = rx_sync && !(^{shift_reg, parity_bit});
`else
   assign frame_ok = rx_sync;
`endif

   // Output stage: one-cycle pulses; data_out only changes on a good frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out    <= 8'h00;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
         if (stop_eval) begin
            if (frame_ok) begin
               data_out   <= shift_reg;
               data_valid <= 1'b1;
            end else begin
               frame_error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600: line bit rate in bits/s.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port data_out, output, 8 bits: last good received byte, feeding the 7-segment display stage.
REQ-007 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out updates.
REQ-008 The block SHALL have port frame_error, output, 1 bit: one-cycle pulse on a bad stop bit (or bad parity, see REQ-022).

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-010 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD using integer division (10416 at defaults); HALF_BIT SHALL equal CLKS_PER_BIT/2.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START: synchronized rx falls (previous 1, current 0); bit counter clears.
REQ-012 In START, the block SHALL sample rx at HALF_BIT clocks.
- rx==0: go to DATA with the bit counter cleared.
- rx==1: glitch; return to IDLE, no output activity.
REQ-013 In DATA, the block SHALL sample rx every CLKS_PER_BIT clocks.
- 8 bits, LSB first, into a shift register.
- After bit 7, go to STOP (or PARITY, see REQ-022).
REQ-014 In STOP, the block SHALL sample rx after CLKS_PER_BIT clocks and then return to IDLE.
- rx==1: data_out <= shift register, and data_valid SHALL pulse for one cycle, both on the clock edge after the sample.
- rx==0: frame_error SHALL pulse for one cycle; data_out SHALL hold its previous value; data_valid SHALL stay 0.
REQ-015 data_out SHALL hold its value between frames; data_valid and frame_error SHALL never be high together.
REQ-016 A line held low after a frame (break) SHALL NOT start a new frame until rx returns high and falls again.
REQ-017 Changes on rx outside the sample points SHALL be ignored.

Reset
REQ-018 While rst_n==0, the block SHALL asynchronously force:
- state to IDLE;
- counters and shift register to 0;
- data_out = 8'h00, data_valid = 0, frame_error = 0;
- synchronizer flops to 1.
REQ-019 A reset mid-frame SHALL abort the frame with no data_valid or frame_error pulse; reception SHALL resume on the next falling edge after rst_n deasserts.

Configuration
REQ-020 Macro UART_RX_PARITY_EN SHALL select whether parity checking is compiled in.
REQ-021 Without UART_RX_PARITY_EN, the frame SHALL be 8N1 and the FSM SHALL have no PARITY state.
REQ-022 With UART_RX_PARITY_EN, the frame SHALL be 8E1.
- The FSM SHALL add state PARITY between DATA and STOP, sampled one bit time after bit 7.
- If the XOR of the 8 data bits and the parity bit is 1, then at STOP frame_error SHALL pulse instead of data_valid, and data_out SHALL hold.
- The port list SHALL be unchanged.

Structure
REQ-023 Package uart_pkg SHALL hold:
- the state enum (IDLE, START, DATA, PARITY, STOP);
- the DATA_BITS=8 constant;
- a function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
REQ-024 Sub-module uart_baud_tick SHALL provide the bit-period counter with a restart input and a tick output at HALF_BIT or CLKS_PER_BIT; the FSM SHALL remain in uart_rx.

Verification (bench uses CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clks/bit)
REQ-025 Byte 8'hA5, 8N1, good stop -> data_out==8'hA5 and a single data_valid pulse within 2 clks of the stop-bit mid-sample; frame_error stays 0.
REQ-026 Low pulse of 3 clks on idle rx -> no data_valid, no frame_error; a following 8'h3C frame is received correctly.
REQ-027 Byte 8'h5A with stop bit 0 -> frame_error pulses once, data_out keeps 8'hA5; line then held low 50 clks -> no new frame until rx rises and falls.
REQ-028 rst_n pulsed low during bit 4 of 8'hFF -> outputs 0 immediately, no pulses; the next 8'h01 frame is received correctly.
REQ-029 Back-to-back 8'h00, 8'hFF, 8'h7E with no idle gap -> three data_valid pulses with the matching data_out values.
REQ-030 With UART_RX_PARITY_EN: 8'h03 with parity 0 -> data_valid; 8'h03 with parity 1 -> frame_error, data_out unchanged.
